arm7tdmi_fetch: RTL and testbench

ARM7TDMI_FETCH -- requirements
Module: arm7tdmi_fetch

---
 rtl/arm7tdmi_pkg.sv | 23 ++
 rtl/arm7tdmi_prefetch_fifo.sv | 56 +++++
 rtl/arm7tdmi_fetch.sv | 120 ++++++++++++
 tb/tb_arm7tdmi_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_pkg.sv
// Shared types and helpers for the ARM7TDMI fetch unit.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] ARM_STEP   = 32'd4;
    localparam logic [31:0] THUMB_STEP = 32'd2;

    // Branch targets are forced to the natural alignment of the instruction set.
    function automatic logic [31:0] align_target(input logic [31:0] addr, input logic thumb);
        return thumb ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm7tdmi_prefetch_fifo.sv
// Small circular prefetch buffer; clear wins over push/pop, push is allowed when full only alongside a pop.
module arm7tdmi_prefetch_fifo
    import arm7tdmi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/arm7tdmi_fetch.sv
// ARM7TDMI instruction fetch: one outstanding memory request feeding the prefetch FIFO.
// Thumb halfword fetch is compiled in only when ARM7_FETCH_THUMB_EN is defined.
module arm7tdmi_fetch
    import arm7tdmi_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        thumb_mode,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(FIFO_DEPTH - 1);

    fetch_state_t  state;
    fetch_state_t  state_d;
    logic [31:0]   fetch_pc;
    logic [31:0]   discard_addr;
    logic [31:0]   step;
    logic [31:0]   push_instr;
    logic [31:0]   target;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          room_after;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

`ifdef ARM7_FETCH_THUMB_EN
    always_comb begin
        step       = thumb_mode ? THUMB_STEP : ARM_STEP;
        push_instr = mem_rdata;
        if (thumb_mode)
            push_instr = {16'h0000, fetch_pc[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
    end
    assign target = align_target(branch_target, thumb_mode);
`else
    logic unused_thumb;
    assign unused_thumb = thumb_mode;
    assign step         = ARM_STEP;
    assign push_instr   = mem_rdata;
    assign target       = align_target(branch_target, 1'b0);
`endif

    assign push       = (state == REQ) && mem_ready && !flush;
    assign pop        = !empty && !stall && !flush;
    // Keep requesting back-to-back only if the entry being pushed leaves a free slot.
    assign room_after = pop || (count < LAST_SLOT);
    assign push_entry = '{instr: push_instr, pc: fetch_pc};

    arm7tdmi_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = (mem_req && !mem_ready) ? DISCARD : REQ;
        end else begin
            case (state)
                IDLE:    if (!full) state_d = REQ;
                REQ:     if (mem_ready && !room_after) state_d = IDLE;
                DISCARD: if (mem_ready) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    // The abandoned request keeps its address on the bus until memory answers it.
    always_comb begin
        mem_req  = (state != IDLE);
        mem_addr = (state == DISCARD) ? discard_addr : {fetch_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_VECTOR;
            discard_addr <= '0;
        end else begin
            if (flush && state != DISCARD) discard_addr <= mem_addr;
            if (flush)     fetch_pc <= target;
            else if (push) fetch_pc <= fetch_pc + step;
        end
    end

    assign instr_valid = !empty;
    assign instruction = empty ? 32'h0 : head.instr;
    assign pc_out      = empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_arm7tdmi_fetch.sv
// Bench for arm7tdmi_fetch: directed vector table, Thumb sequence, randomized stream vs. a PC-sequence model.
module tb_arm7tdmi_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, thumb_mode, mem_ready;
    logic        mem_req, instr_valid;
    logic [31:0] branch_target, mem_addr, mem_rdata, instruction, pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arm7tdmi_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .thumb_mode    (thumb_mode),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    // Memory image: a couple of fixed words for the Thumb case, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'hBEEF_1234;
        if (a == 32'h0000_0204) return 32'hCAFE_1234;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    typedef struct {
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        rst;
        logic        stl;
        logic        fl;
        logic [31:0] tgt;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic r, input logic s,
                                input logic f, input logic [31:0] t, input logic rd);
        vec_t v;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        v.rst = r; v.stl = s; v.fl = f; v.tgt = t; v.rdy = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [31:0] t, input logic rd);
        rst_n = r; stall = s; flush = f; branch_target = t; mem_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    logic [31:0] exp_pc, prev_addr, tgt;
    logic        prev_hold, prev_flush, st, fl, rd, popping;
    int          gap, max_gap;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        thumb_mode = 1'b0;

        // Each row: outputs expected now, then inputs applied for the next edge.
        tbl.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h4,        1, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h8,        1, 32'h4,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'hC,        1, 32'h8,        1, 1, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'h8,        1, 1, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'h8,        1, 1, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'h8,        1, 1, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'h8,        1, 1, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'h8,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       1, 32'hC,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h10,       0, 32'h0,        0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h4,        1, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h8,        1, 32'h4,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h8,        0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h8,        0, 32'h0,        1, 0, 1, 32'h100,      0));
        tbl.push_back(mk(1, 32'h8,        0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h8,        0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h100,      0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h104,      1, 32'h100,      1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h104,      0, 32'h0,        1, 0, 1, 32'hFFFF_FFFE, 0));
        tbl.push_back(mk(1, 32'h104,      0, 32'h0,        1, 0, 1, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0,       1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h0,        1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,       1));
        tbl.push_back(mk(1, 32'h4,        1, 32'h0,        1, 0, 1, 32'h40,       1));
        tbl.push_back(mk(1, 32'h40,       0, 32'h0,        1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 32'h44,       1, 32'h40,       1, 1, 1, 32'h80,       1));
        tbl.push_back(mk(1, 32'h80,       0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h80,       0, 32'h0,        1, 0, 0, 32'h0,        0));

        tick();
        foreach (tbl[i]) begin
            chk($sformatf("row%0d mem_req", i),     32'(mem_req),     32'(tbl[i].e_req));
            chk($sformatf("row%0d mem_addr", i),    mem_addr,         tbl[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d pc_out", i),      pc_out,           tbl[i].e_pc);
            chk($sformatf("row%0d instruction", i), instruction,
                tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 32'h0);
            drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].tgt, tbl[i].rdy);
            tick();
        end

`ifdef ARM7_FETCH_THUMB_EN
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        thumb_mode = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h203, 1'b1);
        tick();
        chk("thumb first addr", mem_addr, 32'h200);
        chk("thumb flush empty", 32'(instr_valid), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk("thumb hi pc", pc_out, 32'h202);
        chk("thumb hi instr", instruction, 32'h0000_BEEF);
        chk("thumb next addr", mem_addr, 32'h204);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk("thumb held pc", pc_out, 32'h202);
        chk("thumb full req", 32'(mem_req), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("thumb lo pc", pc_out, 32'h204);
        chk("thumb lo instr", instruction, 32'h0000_1234);
        thumb_mode = 1'b0;
`endif

        // Randomized run: popped entries must follow target, target+4, ... with matching data.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        exp_pc     = 32'h0;
        prev_hold  = 1'b0;
        prev_flush = 1'b0;
        prev_addr  = 32'h0;
        gap        = 0;
        max_gap    = 0;
        for (int c = 0; c < 4000; c++) begin
            if (prev_flush) chk("rand flush clears", 32'(instr_valid), 32'h0);
            if (prev_hold) begin
                chk("rand req held", 32'(mem_req), 32'h1);
                chk("rand addr held", mem_addr, prev_addr);
            end
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            rd  = ($urandom_range(0, 2) != 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            popping = instr_valid && !st && !fl;
            if (popping) begin
                chk("rand pc_out", pc_out, exp_pc);
                chk("rand instruction", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                gap    = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            if (fl) exp_pc = {tgt[31:2], 2'b00};
            prev_hold  = mem_req && !rd;
            prev_addr  = mem_addr;
            prev_flush = fl;
            drive(1'b1, st, fl, tgt, rd);
            tick();
        end
        chk("rand progress bound", 32'(max_gap < 60), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
